serial_adder_ctrl: RTL and testbench

- Bit-serial add/subtract controller built around the existing 1-bit full-adder cell `adder3b`.
- Loads two WIDTH-bit operands, feeds the adder one bit per clock (LSB first) and holds the carry in a register between bits.
- Assembles the result in a shift register and reports carry-out and signed overflow.
- Trades the area of a wide ripple adder for latency; used wherever a slow, small arithmetic unit is enough.

---
 rtl/serial_adder_ctrl_pkg.sv | 10 +
 rtl/adder3b.sv | 14 +
 rtl/serial_adder_ctrl.sv | 94 +++++++++
 tb/tb_serial_adder_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
package serial_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/adder3b.sv
// 1-bit full-adder cell: sum and carry of three input bits.
// Latency: combinational; backpressure: none.
module adder3b (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract, LSB first, over one adder3b cell; result valid with done.
// Latency: WIDTH cycles in RUN plus one DONE cycle; no backpressure, start is ignored unless idle.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             msb_cin;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             bit_sum;
    logic             bit_carry;
    logic             last_bit;

    adder3b u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .c  (carry),
        .s  (bit_sum),
        .co (bit_carry)
    );

    assign last_bit = (cnt == LAST_BIT);

    // A doubles as the result shift register: each consumed LSB frees the MSB slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            msb_cin <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= op_a;
                        b_sr  <= sub ? ~op_b : op_b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr  <= {bit_sum, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= bit_carry;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        // Results land in dedicated holding flops so they stay put until the next result.
                        sum_q   <= {bit_sum, a_sr[WIDTH-1:1]};
                        cout_q  <= bit_carry;
                        msb_cin <= carry;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = msb_cin ^ cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH = 8: directed scenarios plus random ops vs. an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [9:0] ref_model(input int a, input int b, input bit s, input bit c);
        int sa, sb, ures, sres;
        logic [9:0] r;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        if (s) begin
            ures = a - b;
            sres = sa - sb;
            r[8] = (a >= b);
        end else begin
            ures = a + b + int'(c);
            sres = sa + sb + int'(c);
            r[8] = (ures > 255);
        end
        r[7:0] = 8'(ures & 255);
        r[9]   = (sres < -128) || (sres > 127);
        return r;
    endfunction

    // Leaves the caller at the falling edge right after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic c, input logic [W-1:0] esum,
                                input logic ecout, input logic eovf);
        int cyc, nbusy;
        start_op(a, b, s, c);
        wait_done(cyc, nbusy);
        check({tag, "_latency"}, cyc, W);
        check({tag, "_busy_cycles"}, nbusy, W);
        check({tag, "_busy_in_done"}, busy, 0);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_ovf"}, ovf, eovf);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_sum_held"}, sum, esum);
    endtask

    initial begin
        int cyc, nbusy, ndone;
        logic [9:0] exp;
        logic [W-1:0] ra, rb;
        logic rs, rc;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_outs", {sum, cout, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add, wrap, subtract
        run_directed("add", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1);
        run_directed("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_directed("wrap_cin", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
        run_directed("sub", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_directed("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Handshake: spurious start mid-run, then start held across DONE
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        op_a  = 8'hAA;
        op_b  = 8'h55;
        sub   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, nbusy);
        check("hs_first_latency", cyc, W - 3);
        check("hs_first_sum", sum, 8'h46);
        check("hs_first_flags", {cout, ovf}, 2'b00);
        op_a  = 8'h77;
        op_b  = 8'h11;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("hs_idle_gap_busy", busy, 0);
        check("hs_idle_gap_done", done, 0);
        check("hs_idle_gap_sum", sum, 8'h46);
        @(negedge clk);
        start = 1'b0;
        check("hs_second_accepted", busy, 1);
        repeat (4) @(negedge clk);
        check("hs_sum_stable_midrun", sum, 8'h46);
        wait_done(cyc, nbusy);
        check("hs_second_latency", cyc, W - 4);
        check("hs_second_sum", sum, 8'h88);
        check("hs_second_flags", {cout, ovf}, 2'b01);

        // Reset mid-operation
        start_op(8'hC3, 8'h7E, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_outs", {sum, cout, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_directed("post_rst", 8'h05, 8'h03, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            exp = ref_model(int'(ra), int'(rb), rs, rc);
            start_op(ra, rb, rs, rc);
            wait_done(cyc, nbusy);
            check("rand_cout_sum", {cout, sum}, exp[8:0]);
            check("rand_ovf", ovf, exp[9]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
